// File: rtl/display_bcd_sequencer_if.sv
// Bus between the output-instruction datapath and the BCD display sequencer.
// The master drives the value and strobe; the slave returns busy and digits.
interface display_bcd_sequencer_if;
   logic [31:0] DATA_IN;
   logic        LOAD;
   logic        BUSY;
   logic [6:0]  UNIDADE;
   logic [6:0]  DEZENA;
   logic [6:0]  CENTENA;
   logic [6:0]  MILHAR;
   logic [6:0]  D_MILHAR;
   logic [6:0]  C_MILHAR;
   logic [6:0]  MILHAO;
   logic [6:0]  D_MILHAO;

   modport master (
      output DATA_IN, LOAD,
      input  BUSY, UNIDADE, DEZENA, CENTENA, MILHAR,
      input  D_MILHAR, C_MILHAR, MILHAO, D_MILHAO
   );

   modport slave (
      input  DATA_IN, LOAD,
      output BUSY, UNIDADE, DEZENA, CENTENA, MILHAR,
      output D_MILHAR, C_MILHAR, MILHAO, D_MILHAO
   );
endinterface

// File: rtl/display_bcd_sequencer.sv
// Signed 32-bit to eight-digit seven-segment display via serial double dabble.
// One step per cycle; display registers only update in FINISH.
module display_bcd_sequencer #(
   parameter bit BLANK_LZ       = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input logic CLOCK,
   input logic RESET,
   display_bcd_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

   localparam logic [6:0] SEG_ZERO  = SEG_ACTIVE_LOW ? 7'h40 : 7'h3F;
   localparam logic [6:0] SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   state_t      state_q, state_d;
   logic [31:0] mag_q, bcd_q, pend_val_q;
   logic        sign_q, ov_q, rng_q, pend_q;
   logic [5:0]  cnt_q;
   logic [6:0]  seg_q [8];
   logic [6:0]  seg_d [8];

   logic        start;
   logic [31:0] src, src_mag, adj, bcd_step;
   logic [2:0]  msd;
   logic [6:0]  g;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'd0:    glyph = 7'h3F;
         4'd1:    glyph = 7'h06;
         4'd2:    glyph = 7'h5B;
         4'd3:    glyph = 7'h4F;
         4'd4:    glyph = 7'h66;
         4'd5:    glyph = 7'h6D;
         4'd6:    glyph = 7'h7D;
         4'd7:    glyph = 7'h07;
         4'd8:    glyph = 7'h7F;
         4'd9:    glyph = 7'h6F;
         default: glyph = 7'h00;
      endcase
   endfunction

   always_ff @(posedge CLOCK) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // A LOAD seen in FINISH starts the next conversion without visiting IDLE
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      src     = bus.DATA_IN;
      unique case (state_q)
         IDLE: begin
            if (bus.LOAD) begin
               start   = 1'b1;
               state_d = CONVERT;
            end
         end
         CONVERT: begin
            if (cnt_q == 6'd32) state_d = FINISH;
         end
         FINISH: begin
            if (pend_q || bus.LOAD) begin
               start   = 1'b1;
               state_d = CONVERT;
               if (pend_q) src = pend_val_q;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign src_mag = src[31] ? (~src + 32'd1) : src;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < 8; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_step = {adj[30:0], mag_q[31]};
   end

   always_comb begin
      msd = '0;
      for (int i = 1; i < 8; i++) begin
         if (bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
      end
   end

   always_comb begin
      g = '0;
      for (int i = 0; i < 8; i++) begin
         if (ov_q || rng_q) begin
            g = 7'h79;
         end else if (BLANK_LZ) begin
            if (i <= int'(msd))                      g = glyph(bcd_q[4*i +: 4]);
            else if (sign_q && i == int'(msd) + 1) g = 7'h40;
            else                                     g = 7'h00;
         end else begin
            if (sign_q && i == 7) g = 7'h40;
            else                  g = glyph(bcd_q[4*i +: 4]);
         end
         seg_d[i] = SEG_ACTIVE_LOW ? ~g : g;
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         mag_q      <= '0;
         bcd_q      <= '0;
         pend_val_q <= '0;
         sign_q     <= 1'b0;
         ov_q       <= 1'b0;
         rng_q      <= 1'b0;
         pend_q     <= 1'b0;
         cnt_q      <= '0;
         seg_q[0]   <= SEG_ZERO;
         for (int i = 1; i < 8; i++) seg_q[i] <= BLANK_LZ ? SEG_BLANK : SEG_ZERO;
      end else begin
         if (start) begin
            sign_q <= src[31];
            mag_q  <= src_mag;
            rng_q  <= src[31] ? (src_mag > 32'd9999999) : (src_mag > 32'd99999999);
            bcd_q  <= '0;
            ov_q   <= 1'b0;
            cnt_q  <= '0;
         end else if (state_q == CONVERT && cnt_q != 6'd32) begin
            bcd_q <= bcd_step;
            mag_q <= {mag_q[30:0], 1'b0};
            ov_q  <= ov_q | adj[31];
            cnt_q <= cnt_q + 6'd1;
         end
         if (state_q == FINISH) begin
            for (int i = 0; i < 8; i++) seg_q[i] <= seg_d[i];
         end
         // Only the newest value waiting behind a busy conversion survives
         if (state_q == CONVERT && bus.LOAD) begin
            pend_q     <= 1'b1;
            pend_val_q <= bus.DATA_IN;
         end else if (state_q == FINISH) begin
            pend_q <= pend_q & bus.LOAD;
            if (bus.LOAD) pend_val_q <= bus.DATA_IN;
         end
      end
   end

   assign bus.BUSY     = (state_q != IDLE);
   assign bus.UNIDADE  = seg_q[0];
   assign bus.DEZENA   = seg_q[1];
   assign bus.CENTENA  = seg_q[2];
   assign bus.MILHAR   = seg_q[3];
   assign bus.D_MILHAR = seg_q[4];
   assign bus.C_MILHAR = seg_q[5];
   assign bus.MILHAO   = seg_q[6];
   assign bus.D_MILHAO = seg_q[7];
endmodule

// File: tb/tb_display_bcd_sequencer.sv
// Bench for display_bcd_sequencer: three parameter sets driven in lockstep
// and compared against a decimal-arithmetic model of the display.
module tb_display_bcd_sequencer;
   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic [31:0] data  = '0;
   logic        load  = 1'b0;

   int checks   = 0;
   int failures = 0;

   logic [31:0] shown;
   bit          shown_rst;

   display_bcd_sequencer_if ia ();
   display_bcd_sequencer_if ib ();
   display_bcd_sequencer_if ic ();

   assign ia.DATA_IN = data;
   assign ib.DATA_IN = data;
   assign ic.DATA_IN = data;
   assign ia.LOAD    = load;
   assign ib.LOAD    = load;
   assign ic.LOAD    = load;

   display_bcd_sequencer #(.BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut_a (
      .CLOCK(CLOCK), .RESET(RESET), .bus(ia));
   display_bcd_sequencer #(.BLANK_LZ(1'b0), .SEG_ACTIVE_LOW(1'b1)) dut_b (
      .CLOCK(CLOCK), .RESET(RESET), .bus(ib));
   display_bcd_sequencer #(.BLANK_LZ(1'b1), .SEG_ACTIVE_LOW(1'b0)) dut_c (
      .CLOCK(CLOCK), .RESET(RESET), .bus(ic));

   always #5 CLOCK = ~CLOCK;

   logic [55:0] da, db, dc;
   logic [2:0]  busy3;
   assign da = {ia.D_MILHAO, ia.MILHAO, ia.C_MILHAR, ia.D_MILHAR,
                ia.MILHAR, ia.CENTENA, ia.DEZENA, ia.UNIDADE};
   assign db = {ib.D_MILHAO, ib.MILHAO, ib.C_MILHAR, ib.D_MILHAR,
                ib.MILHAR, ib.CENTENA, ib.DEZENA, ib.UNIDADE};
   assign dc = {ic.D_MILHAO, ic.MILHAO, ic.C_MILHAR, ic.D_MILHAR,
                ic.MILHAR, ic.CENTENA, ic.DEZENA, ic.UNIDADE};
   assign busy3 = {ia.BUSY, ib.BUSY, ic.BUSY};

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'h3F;
         1: return 7'h06;
         2: return 7'h5B;
         3: return 7'h4F;
         4: return 7'h66;
         5: return 7'h6D;
         6: return 7'h7D;
         7: return 7'h07;
         8: return 7'h7F;
         default: return 7'h6F;
      endcase
   endfunction

   // Decimal view of the displayed value, digit i weighs 10**i
   function automatic logic [55:0] model(input logic [31:0] v,
                                         input bit blank, input bit low);
      longint unsigned m, pw;
      bit s, over;
      int nd, d;
      logic [6:0] gl;
      logic [55:0] r;
      s  = v[31];
      m  = s ? (64'h1_0000_0000 - {32'h0, v}) : {32'h0, v};
      over = s ? (m > 64'd9999999) : (m > 64'd99999999);
      nd = 1;
      pw = 10;
      while (nd < 8 && m >= pw) begin
         nd++;
         pw = pw * 10;
      end
      pw = 1;
      r  = '0;
      for (int i = 0; i < 8; i++) begin
         d  = int'((m / pw) % 10);
         pw = pw * 10;
         if (over)                gl = 7'h79;
         else if (blank) begin
            if (i < nd)           gl = glyph(d);
            else if (s && i == nd) gl = 7'h40;
            else                  gl = 7'h00;
         end else if (s && i == 7) gl = 7'h40;
         else                     gl = glyph(d);
         r[7*i +: 7] = low ? ~gl : gl;
      end
      return r;
   endfunction

   function automatic logic [55:0] reset_model(input bit blank, input bit low);
      logic [55:0] r;
      for (int i = 0; i < 8; i++) begin
         r[7*i +: 7] = (i == 0 || !blank) ? 7'h3F : 7'h00;
         if (low) r[7*i +: 7] = ~r[7*i +: 7];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [55:0] obs,
                      input logic [55:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic chk_disp(input string tag);
      logic [55:0] ea, eb, ec;
      if (shown_rst) begin
         ea = reset_model(1'b1, 1'b1);
         eb = reset_model(1'b0, 1'b1);
         ec = reset_model(1'b1, 1'b0);
      end else begin
         ea = model(shown, 1'b1, 1'b1);
         eb = model(shown, 1'b0, 1'b1);
         ec = model(shown, 1'b1, 1'b0);
      end
      chk({tag, "_a"}, da, ea);
      chk({tag, "_b"}, db, eb);
      chk({tag, "_c"}, dc, ec);
   endtask

   task automatic run_one(input logic [31:0] v);
      data = v;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("busy_start", 56'(busy3), 56'h7);
      for (int k = 1; k <= 33; k++) begin
         tick();
         chk("busy_conv", 56'(busy3), 56'h7);
      end
      chk_disp("hold_old");
      tick();
      chk("busy_done", 56'(busy3), 56'h0);
      shown     = v;
      shown_rst = 1'b0;
      chk_disp("result");
   endtask

   // First load at edge N; second at N+t2, optional third at N+t3
   task automatic run_chain(input logic [31:0] v1, input logic [31:0] v2,
                            input int t2, input logic [31:0] v3, input int t3);
      logic [31:0] fin;
      fin  = (t3 > 0) ? v3 : v2;
      data = v1;
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int e = 1; e <= 68; e++) begin
         if (e == t2) begin
            data = v2;
            load = 1'b1;
         end
         if (t3 > 0 && e == t3) begin
            data = v3;
            load = 1'b1;
         end
         tick();
         load = 1'b0;
         if (e <= 67) chk("chain_busy", 56'(busy3), 56'h7);
         if (e == 33) chk_disp("chain_old");
         if (e == 34) begin
            shown     = v1;
            shown_rst = 1'b0;
            chk_disp("chain_first");
         end
         if (e == 67) chk_disp("chain_hold");
         if (e == 68) begin
            chk("chain_idle", 56'(busy3), 56'h0);
            shown = fin;
            chk_disp("chain_final");
         end
      end
   endtask

   initial begin
      logic [31:0] r, v;
      shown_rst = 1'b1;
      shown     = '0;

      // Reset with LOAD asserted: reset must win
      RESET = 1'b1;
      load  = 1'b1;
      data  = 32'd123;
      tick();
      tick();
      chk("reset_busy", 56'(busy3), 56'h0);
      chk_disp("reset_disp");
      RESET = 1'b0;
      load  = 1'b0;
      tick();
      chk("reset_idle", 56'(busy3), 56'h0);

      run_one(32'd12345);
      chk("lit_12345_u", 56'(ia.UNIDADE), 56'h12);
      chk("lit_12345_dm", 56'(ia.D_MILHAR), 56'h79);
      chk("lit_12345_cm", 56'(ia.C_MILHAR), 56'h7F);
      run_one(32'hFFFF_FFF9);
      chk("lit_m7_u", 56'(ia.UNIDADE), 56'h78);
      chk("lit_m7_d", 56'(ia.DEZENA), 56'h3F);
      run_one(32'd99999999);
      run_one(32'd100000000);
      run_one(-32'sd10000000);
      run_one(32'h8000_0000);
      run_one(32'd0);
      chk("lit_zero_u", 56'(ia.UNIDADE), 56'h40);
      chk("lit_zero_b", db, {8{7'h40}});
      run_one(-32'sd9999999);
      run_one(32'h7FFF_FFFF);
      run_one(32'd10);

      for (int n = 0; n < 16; n++) begin
         r = $urandom;
         case ($urandom_range(0, 3))
            0:       v = r;
            1:       v = r % 32'd100000000;
            2:       v = -(r % 32'd10000000);
            default: v = -(r % 32'd100);
         endcase
         run_one(v);
      end

      run_chain(32'd5, 32'd42, 10, 32'd8, 20);
      run_chain(32'd11, -32'sd222, 34, 32'd0, 0);

      // Reset in the middle of a conversion
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      shown_rst = 1'b1;
      chk_disp("rst2_disp");
      data = 32'd777;
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int k = 1; k <= 15; k++) tick();
      chk("abort_busy_pre", 56'(busy3), 56'h7);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      chk("abort_busy", 56'(busy3), 56'h0);
      chk_disp("abort_disp");
      for (int k = 0; k < 30; k++) tick();
      chk("abort_idle", 56'(busy3), 56'h0);
      chk_disp("abort_hold");
      run_one(32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/display_bcd_sequencer.md
DISPLAY_BCD_SEQUENCER -- requirements
Module: display_bcd_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; these are CLOCK and RESET.
REQ-002 Parameter BLANK_LZ, default 1, SHALL blank leading zero digits when set.
REQ-003 Parameter SEG_ACTIVE_LOW, default 1, SHALL invert all segment outputs when set, so segment on = 0.
REQ-004 CLOCK  input  1  the processor clock, i.e. the debounced step clock.
REQ-005 RESET  input  1  synchronous, active-high reset.
REQ-006 DATA_IN  input  32  two's-complement value to display, i.e. the register-file RT read data.
REQ-007 LOAD  input  1  capture strobe, i.e. the output-instruction control.
REQ-008 BUSY  output  1  conversion in progress.
REQ-009 UNIDADE, DEZENA, CENTENA, MILHAR, D_MILHAR, C_MILHAR, MILHAO, D_MILHAO  output  7 each  seven-segment digits, least to most significant; bit0 = a through bit6 = g.

Function
REQ-010 The FSM SHALL have three states: IDLE, CONVERT and FINISH.
REQ-011 IDLE with LOAD=1 SHALL latch DATA_IN, set sign S = DATA_IN[31] and magnitude M = |DATA_IN| as 32-bit unsigned, clear the 32-bit BCD accumulator and go to CONVERT.
REQ-012 M for 0x80000000 SHALL be 2147483648 with no wrap-around.
REQ-013 CONVERT SHALL run one double-dabble step per cycle for exactly 32 cycles.
REQ-014 Each step SHALL first add 3 to every BCD nibble that is 5 or more, then shift {BCD, M} left by one.
REQ-015 Any carry out of the top nibble SHALL set a sticky overflow flag OV.
REQ-016 After the 32nd step, CONVERT SHALL go to FINISH.
REQ-017 FINISH, lasting one cycle, SHALL write all eight display registers and then go to IDLE.
REQ-018 BUSY SHALL be 1 in CONVERT and FINISH and 0 in IDLE.
REQ-019 Latency SHALL be 34 cycles: LOAD sampled at edge N, BUSY high after edges N to N+33, new digits visible after edge N+34, BUSY low after edge N+34.
REQ-020 Overflow SHALL be declared when OV=1, or S=0 and M > 99999999, or S=1 and M > 9999999.
REQ-021 On overflow, all eight digits SHALL show "E".
REQ-022 Without overflow, each digit SHALL show its BCD nibble using the glyph set 0-9.
REQ-023 With BLANK_LZ=1, zero digits above the most significant non-zero digit SHALL be blank; UNIDADE SHALL never be blank.
REQ-024 With S=1 and no overflow, the digit just above the most significant non-zero digit SHALL show minus (segment g only).
REQ-025 With BLANK_LZ=0, the minus SHALL go in D_MILHAO and the other digits SHALL show 0.
REQ-026 Active-high glyphs, before SEG_ACTIVE_LOW inversion, SHALL be: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, E=0x79, minus=0x40, blank=0x00.
REQ-027 A LOAD while BUSY=1 SHALL set a pending flag and overwrite a pending value register; only the newest pending value is kept.
REQ-028 FINISH with pending set SHALL clear the flag, load the pending value exactly as REQ-011 and go to CONVERT, not IDLE; BUSY SHALL stay 1.
REQ-029 A LOAD in FINISH SHALL be treated as pending.
REQ-030 Display registers SHALL change only in FINISH (or reset) and SHALL hold between conversions; they SHALL never show partial results.
REQ-031 The step counter SHALL be 6 bits and SHALL wrap to 0 on entering CONVERT.

Reset
REQ-032 RESET=1 at a CLOCK edge SHALL force IDLE with BUSY=0 and clear the pending flag, OV, the accumulator and the counter.
REQ-033 Reset SHALL show "0" on UNIDADE and blank on the other digits; with BLANK_LZ=0, all digits SHALL show "0".
REQ-034 RESET SHALL take priority over LOAD.
REQ-035 Reset mid-CONVERT SHALL abort the conversion with no display update.

Verification
REQ-036 Reset, then LOAD with DATA_IN=12345 -> BUSY high for 34 cycles; SEG_ACTIVE_LOW=1 outputs UNIDADE=0x12, DEZENA=0x19, CENTENA=0x30, MILHAR=0x24, D_MILHAR=0x79, upper three digits 0x7F.
REQ-037 LOAD with DATA_IN=-7 (0xFFFFFFF9) -> UNIDADE shows 7 (0x78), DEZENA shows minus (0x3F), rest blank (0x7F).
REQ-038 LOAD with 99999999 -> all digits 9 (0x10); LOAD with 100000000, -10000000 and 0x80000000 -> all digits E (0x06).
REQ-039 LOAD 5 at edge N, LOAD 42 at N+10, LOAD 8 at N+20 -> display shows 5 after edge N+34, then 8 after edge N+68; 42 is never displayed; BUSY is continuously high from N to N+67.
REQ-040 LOAD 777, then RESET at cycle 15 of CONVERT -> BUSY=0 on the next edge, display stays at the reset pattern, and a following LOAD 3 shows 3 after 34 cycles.
REQ-041 LOAD 0 -> UNIDADE 0x40, rest 0x7F; with BLANK_LZ=0 -> all 0x40.
